// File: rtl/score_pkg.sv
// score_pkg: shared state encodings and default cycle counts for the scoreboard input sequencer.
// Latency: n/a (types, constants and an elaboration helper only).
// Backpressure: n/a. SCORE_MAX is shared with the 0..99 counter instances.
package score_pkg;

    // Per-team channel states; WAIT_REL is only reachable when auto-repeat is compiled out
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HOLD     = 3'd1,
        REPEAT   = 3'd2,
        BLOCK    = 3'd3,
        WAIT_REL = 3'd4
    } chan_state_e;

    // Clear-gesture states
    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_WAIT = 2'd1,
        C_FIRE = 2'd2,
        C_DONE = 2'd3
    } clr_state_e;

    localparam logic [15:0] HOLD_CYCLES_DEF   = 16'd50000;
    localparam logic [15:0] REPEAT_CYCLES_DEF = 16'd10000;
    localparam logic [23:0] CLR_CYCLES_DEF    = 24'd200000;
    localparam int unsigned CW_DEF            = 24;

    // Upper limit of the score counters driven by this block
    localparam int unsigned SCORE_MAX = 99;

    // True when val can be loaded into a cw-bit timer without truncation
    function automatic logic fits_cw(input int unsigned cw, input logic [31:0] val);
        if (cw >= 32) begin
            return 1'b1;
        end
        return (val >> cw) == 32'd0;
    endfunction

endpackage

// File: rtl/score_btn_chan.sv
// score_btn_chan: turns one team's up/down button levels into single-cycle up/down pulses.
// Latency: edge sampled in cycle n -> pulse in cycle n+1; all outputs registered.
// Backpressure: none; suppress_dn_i masks down auto-repeat pulses only. Auto-repeat needs SCORE_CTRL_AUTO_REPEAT_EN.
module score_btn_chan
    import score_pkg::*;
`ifdef SCORE_CTRL_AUTO_REPEAT_EN
#(
    parameter logic [15:0] HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter logic [15:0] REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int unsigned CW            = CW_DEF
)
`endif
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic up_i,
    input  logic dn_i,
    input  logic suppress_dn_i,
    output logic up_o,
    output logic dn_o
);

    chan_state_e state_q, state_d;
    logic        up_prev_q, dn_prev_q;
    logic        dir_up_q, dir_up_d;   // which button owns the current press
    logic        up_q, up_d;
    logic        dn_q, dn_d;
    logic        up_rise, dn_rise;
    logic        held;

    assign up_rise = up_i & ~up_prev_q;
    assign dn_rise = dn_i & ~dn_prev_q;
    assign held    = dir_up_q ? up_i : dn_i;

`ifdef SCORE_CTRL_AUTO_REPEAT_EN
    logic [CW-1:0] timer_q, timer_d;
    logic          other;

    assign other = dir_up_q ? dn_i : up_i;
`else
    // Only auto-repeat pulses can be suppressed, and there are none in this build
    logic unused_suppress;
    assign unused_suppress = suppress_dn_i;
`endif

    // Next-state and pulse decode for the channel FSM
    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        up_d     = 1'b0;
        dn_d     = 1'b0;
`ifdef SCORE_CTRL_AUTO_REPEAT_EN
        timer_d  = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (up_i && dn_i) begin
                    // Conflicting request from one team: ignore until both released
                    state_d = BLOCK;
                end else if (up_rise || dn_rise) begin
                    up_d     = up_rise;
                    dn_d     = dn_rise;
                    dir_up_d = up_rise;
`ifdef SCORE_CTRL_AUTO_REPEAT_EN
                    timer_d  = CW'(HOLD_CYCLES - 16'd1);
                    state_d  = HOLD;
`else
                    state_d  = WAIT_REL;
`endif
                end
            end
`ifdef SCORE_CTRL_AUTO_REPEAT_EN
            HOLD, REPEAT: begin
                if (!held) begin
                    state_d = IDLE;
                end else if (other) begin
                    state_d = BLOCK;
                end else if (timer_q == '0) begin
                    up_d    = dir_up_q;
                    dn_d    = !dir_up_q && !suppress_dn_i;
                    timer_d = CW'(REPEAT_CYCLES - 16'd1);
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q - CW'(1);
                end
            end
`else
            WAIT_REL: begin
                if (!held) begin
                    state_d = IDLE;
                end
            end
`endif
            BLOCK: begin
                if (!up_i && !dn_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, edge history and output registers; history resets high so a held button needs a re-press
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            up_prev_q <= 1'b1;
            dn_prev_q <= 1'b1;
            dir_up_q  <= 1'b0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
`ifdef SCORE_CTRL_AUTO_REPEAT_EN
            timer_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            up_prev_q <= up_i;
            dn_prev_q <= dn_i;
            dir_up_q  <= dir_up_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
`ifdef SCORE_CTRL_AUTO_REPEAT_EN
            timer_q   <= timer_d;
`endif
        end
    end

    assign up_o = up_q;
    assign dn_o = dn_q;

endmodule

// File: rtl/score_ctrl.sv
// score_ctrl: button sequencer for the two-team scoreboard: up/down pulses per team plus a hold-both-downs clear.
// Latency: edge in cycle n -> pulse in cycle n+1; clr_o follows CLR_CYCLES of both downs held; all outputs registered.
// Backpressure: none. Auto-repeat while held is compiled in only with SCORE_CTRL_AUTO_REPEAT_EN defined.
module score_ctrl
    import score_pkg::*;
#(
    parameter logic [15:0] HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter logic [15:0] REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter logic [23:0] CLR_CYCLES    = CLR_CYCLES_DEF,
    parameter int unsigned CW            = CW_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_up0_i,
    input  logic btn_dn0_i,
    input  logic btn_up1_i,
    input  logic btn_dn1_i,
    output logic up0_o,
    output logic down0_o,
    output logic up1_o,
    output logic down1_o,
    output logic clr_o
);

    // Every cycle count shares the CW-bit timers; refuse to build if one would truncate
    if (!(fits_cw(CW, 32'(HOLD_CYCLES)) && fits_cw(CW, 32'(REPEAT_CYCLES)) &&
          fits_cw(CW, 32'(CLR_CYCLES)))) begin : g_cfg_too_wide
        $error("score_ctrl: a cycle-count parameter does not fit in CW bits");
    end

    clr_state_e    cstate_q, cstate_d;
    logic [CW-1:0] ctimer_q, ctimer_d;
    logic          clr_q, clr_d;
    logic          both_dn;
    logic          suppress_dn;

    assign both_dn     = btn_dn0_i & btn_dn1_i;
    // Once a clear gesture is under way, held downs must not keep decrementing
    assign suppress_dn = (cstate_q != C_IDLE);

    // Next-state decode for the clear gesture; one clr pulse per gesture
    always_comb begin
        cstate_d = cstate_q;
        ctimer_d = ctimer_q;
        clr_d    = 1'b0;
        case (cstate_q)
            C_IDLE: begin
                if (both_dn) begin
                    ctimer_d = CW'(CLR_CYCLES - 24'd1);
                    cstate_d = C_WAIT;
                end
            end
            C_WAIT: begin
                if (!both_dn) begin
                    cstate_d = C_IDLE;
                end else if (ctimer_q == '0) begin
                    clr_d    = 1'b1;
                    cstate_d = C_FIRE;
                end else begin
                    ctimer_d = ctimer_q - CW'(1);
                end
            end
            C_FIRE: cstate_d = C_DONE;
            C_DONE: begin
                if (!btn_dn0_i && !btn_dn1_i) begin
                    cstate_d = C_IDLE;
                end
            end
            default: cstate_d = C_IDLE;
        endcase
    end

    // Clear FSM state, timer and registered clr output
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cstate_q <= C_IDLE;
            ctimer_q <= '0;
            clr_q    <= 1'b0;
        end else begin
            cstate_q <= cstate_d;
            ctimer_q <= ctimer_d;
            clr_q    <= clr_d;
        end
    end

    assign clr_o = clr_q;

    score_btn_chan
`ifdef SCORE_CTRL_AUTO_REPEAT_EN
    #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .CW            (CW)
    )
`endif
    u_chan0 (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .up_i          (btn_up0_i),
        .dn_i          (btn_dn0_i),
        .suppress_dn_i (suppress_dn),
        .up_o          (up0_o),
        .dn_o          (down0_o)
    );

    score_btn_chan
`ifdef SCORE_CTRL_AUTO_REPEAT_EN
    #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .CW            (CW)
    )
`endif
    u_chan1 (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .up_i          (btn_up1_i),
        .dn_i          (btn_dn1_i),
        .suppress_dn_i (suppress_dn),
        .up_o          (up1_o),
        .dn_o          (down1_o)
    );

endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: scoreboard bench for score_ctrl with HOLD=8, REPEAT=4, CLR=20.
// Expected pulses are queued with their cycle when buttons are driven and compared every cycle.
// Repeat expectations follow SCORE_CTRL_AUTO_REPEAT_EN, matching the build of the design.
module tb_score_ctrl;

    localparam int HOLD = 8;
    localparam int REP  = 4;
    localparam int CLR  = 20;

    localparam logic [4:0] M_UP0 = 5'b00001;
    localparam logic [4:0] M_DN0 = 5'b00010;
    localparam logic [4:0] M_UP1 = 5'b00100;
    localparam logic [4:0] M_DN1 = 5'b01000;
    localparam logic [4:0] M_CLR = 5'b10000;

    typedef struct {
        int         cyc;
        logic [4:0] mask;
    } exp_t;

    logic clk;
    logic rst;
    logic up0, dn0, up1, dn1;
    logic up0_o, down0_o, up1_o, down1_o, clr_o;

    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    logic [4:0] exp_m;
    logic [4:0] obs;

    score_ctrl #(
        .HOLD_CYCLES   (16'd8),
        .REPEAT_CYCLES (16'd4),
        .CLR_CYCLES    (24'd20),
        .CW            (24)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .btn_up0_i (up0),
        .btn_dn0_i (dn0),
        .btn_up1_i (up1),
        .btn_dn1_i (dn1),
        .up0_o     (up0_o),
        .down0_o   (down0_o),
        .up1_o     (up1_o),
        .down1_o   (down1_o),
        .clr_o     (clr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int c, input logic [4:0] m);
        exp_t x;
        x.cyc  = c;
        x.mask = m;
        sb.push_back(x);
    endtask

    // A press first sampled at cycle e and held for len cycles
    task automatic push_hold(input int e, input int len, input logic [4:0] m);
        push_exp(e, m);
`ifdef SCORE_CTRL_AUTO_REPEAT_EN
        for (int t = e + HOLD; t < e + len; t += REP) begin
            push_exp(t, m);
        end
`endif
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare all outputs every cycle against whatever the scoreboard says is due now
    always @(posedge clk) begin
        #1;
        exp_m = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                exp_m = exp_m | sb[i].mask;
                sb.delete(i);
            end
        end
        obs = {clr_o, down1_o, up1_o, down0_o, up0_o};
        chk($sformatf("pulses_c%0d", cyc), 32'(obs), 32'(exp_m));
    end

    initial begin
        int e;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        up0 = 1'b1;
        dn0 = 1'b0;
        up1 = 1'b0;
        dn1 = 1'b0;

        // Reset with up0 already held: nothing until release and re-press
        wait_cyc(3);
        chk("reset_outs", 32'({clr_o, down1_o, up1_o, down0_o, up0_o}), 32'd0);
        rst = 1'b0;
        wait_cyc(6);
        up0 = 1'b0;
        wait_cyc(3);
        up0 = 1'b1;
        e = cyc + 1;
        push_hold(e, 3, M_UP0);
        wait_cyc(3);
        up0 = 1'b0;
        wait_cyc(6);

        // Short tap on up1
        up1 = 1'b1;
        e = cyc + 1;
        push_hold(e, 3, M_UP1);
        wait_cyc(3);
        up1 = 1'b0;
        wait_cyc(6);

        // Long hold on up0: edge pulse plus auto-repeat
        up0 = 1'b1;
        e = cyc + 1;
        push_hold(e, 24, M_UP0);
        wait_cyc(24);
        up0 = 1'b0;
        wait_cyc(8);

        // Same-cycle up/down conflict on team 0, then a clean down press
        up0 = 1'b1;
        dn0 = 1'b1;
        wait_cyc(10);
        up0 = 1'b0;
        dn0 = 1'b0;
        wait_cyc(3);
        dn0 = 1'b1;
        e = cyc + 1;
        push_hold(e, 2, M_DN0);
        wait_cyc(2);
        dn0 = 1'b0;
        wait_cyc(5);

        // Clear gesture: one edge decrement per team, no repeats, single clr
        dn0 = 1'b1;
        dn1 = 1'b1;
        e = cyc + 1;
        push_exp(e, M_DN0 | M_DN1);
        push_exp(e + CLR, M_CLR);
        wait_cyc(30);
        dn0 = 1'b0;
        dn1 = 1'b0;
        wait_cyc(6);

        // Reset while dn1 is repeating; held button stays silent until re-pressed
        dn1 = 1'b1;
        e = cyc + 1;
        push_hold(e, 16, M_DN1);
        wait_cyc(16);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(12);
        dn1 = 1'b0;
        wait_cyc(3);
        dn1 = 1'b1;
        e = cyc + 1;
        push_hold(e, 2, M_DN1);
        wait_cyc(2);
        dn1 = 1'b0;
        wait_cyc(6);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
